// File: rtl/dct_pkg.sv
// Shared types, block geometry and full-adder cells for the DCT butterfly stage.
package dct_pkg;

  typedef enum logic {LOAD, EMIT} bfly_state_t;

  localparam int N_POINTS = 8;
  localparam int HALF     = N_POINTS / 2;

  // An approximate cell drops the carry-in from the sum and keeps only a&b as carry-out.
  function automatic logic fa_s(input logic a, input logic b, input logic c, input logic apx);
    fa_s = apx ? (a ^ b) : (a ^ b ^ c);
  endfunction

  function automatic logic fa_c(input logic a, input logic b, input logic c, input logic apx);
    fa_c = apx ? (a & b) : ((a & b) | (c & (a ^ b)));
  endfunction

endpackage

// File: rtl/bfly_addsub.sv
// Shared sum/difference unit: two ripple-carry full-adder chains over sign-extended operands,
// with the low APPROX_BITS cells switchable to approximate adders.
module bfly_addsub
  import dct_pkg::fa_s, dct_pkg::fa_c;
#(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic signed [SIZE-1:0] a,
  input  logic signed [SIZE-1:0] b,
  input  logic                   approx_en,
  output logic signed [SIZE:0]   sum,
  output logic signed [SIZE:0]   diff
);

  logic [SIZE:0] w_ax;
  logic [SIZE:0] w_bx;
  logic [SIZE:0] w_bn;
  logic [SIZE:0] w_cs;
  logic [SIZE:0] w_cd;
  logic [SIZE:0] w_s;
  logic [SIZE:0] w_d;

  assign w_ax  = {a[SIZE-1], a};
  assign w_bx  = {b[SIZE-1], b};
  assign w_bn  = ~w_bx;
  assign w_cs[0] = 1'b0;
  assign w_cd[0] = 1'b1;

  // Difference is a + ~b + 1; the final carry-out of either chain is discarded.
  for (genvar i = 0; i <= SIZE; i++) begin : g_bit
    localparam bit APX = (i < APPROX_BITS);
    assign w_s[i] = fa_s(w_ax[i], w_bx[i], w_cs[i], approx_en & APX);
    assign w_d[i] = fa_s(w_ax[i], w_bn[i], w_cd[i], approx_en & APX);
    if (i < SIZE) begin : g_carry
      assign w_cs[i+1] = fa_c(w_ax[i], w_bx[i], w_cs[i], approx_en & APX);
      assign w_cd[i+1] = fa_c(w_ax[i], w_bn[i], w_cd[i], approx_en & APX);
    end
  end

  assign sum  = signed'(w_s);
  assign diff = signed'(w_d);

endmodule

// File: rtl/dct_butterfly_stage.sv
// First DCT butterfly: buffers x0..x7, then emits registered (x[k]+x[7-k], x[k]-x[7-k]) for k=0..3.
module dct_butterfly_stage
  import dct_pkg::bfly_state_t, dct_pkg::LOAD, dct_pkg::EMIT, dct_pkg::HALF;
#(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0,
  parameter int N_POINTS    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [SIZE-1:0] in_data,
  input  logic                   approx_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [SIZE:0]   out_sum,
  output logic signed [SIZE:0]   out_diff,
  output logic [1:0]             out_idx,
  output logic                   out_last
);

  logic signed [SIZE-1:0] r_buf [N_POINTS];
  bfly_state_t            r_state;
  bfly_state_t            w_state_next;
  logic [2:0]             r_cnt;
  logic [1:0]             r_k;
  logic [1:0]             w_k_next;
  logic                   r_approx;
  logic                   r_out_valid;
  logic                   r_last;
  logic [1:0]             r_idx;
  logic signed [SIZE:0]   r_sum;
  logic signed [SIZE:0]   r_diff;

  logic                   w_acc_in;
  logic                   w_acc_out;
  logic                   w_load_done;
  logic                   w_k_last;
  logic                   w_adv;
  logic [2:0]             w_idx_a;
  logic [2:0]             w_idx_b;
  logic signed [SIZE-1:0] w_op_a;
  logic signed [SIZE-1:0] w_op_b;
  logic signed [SIZE:0]   w_sum;
  logic signed [SIZE:0]   w_diff;

  assign in_ready    = (r_state == LOAD);
  assign w_acc_in    = in_ready & in_valid;
  assign w_acc_out   = (r_state == EMIT) & out_ready;
  assign w_k_last    = (r_k == 2'(HALF - 1));
  assign w_load_done = w_acc_in & (r_cnt == 3'(N_POINTS - 1));
  assign w_adv       = w_load_done | (w_acc_out & ~w_k_last);

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    case (r_state)
      LOAD: begin
        if (w_load_done) begin
          w_state_next = EMIT;
          w_k_next     = 2'd0;
        end
      end
      EMIT: begin
        if (w_acc_out) begin
          if (w_k_last) w_state_next = LOAD;
          else          w_k_next     = r_k + 2'd1;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // x7 is still on in_data during the load-done beat, so it bypasses the buffer for pair k=0.
  assign w_idx_a = {1'b0, w_k_next};
  assign w_idx_b = 3'(N_POINTS - 1) - w_idx_a;
  assign w_op_a  = r_buf[w_idx_a];
  assign w_op_b  = in_ready ? in_data : r_buf[w_idx_b];

  bfly_addsub #(
    .SIZE        (SIZE),
    .APPROX_BITS (APPROX_BITS)
  ) u_addsub (
    .a         (w_op_a),
    .b         (w_op_b),
    .approx_en (r_approx),
    .sum       (w_sum),
    .diff      (w_diff)
  );

  always_ff @(posedge clk) begin
    if (w_acc_in) r_buf[r_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_cnt       <= 3'd0;
      r_k         <= 2'd0;
      r_approx    <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_diff      <= '0;
      r_idx       <= 2'd0;
      r_last      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      if (w_acc_in) r_cnt <= r_cnt + 3'd1;
      if (w_acc_in && (r_cnt == 3'd0)) r_approx <= approx_en;
      if (w_load_done)                r_out_valid <= 1'b1;
      else if (w_acc_out && w_k_last) r_out_valid <= 1'b0;
      if (w_adv) begin
        r_sum  <= w_sum;
        r_diff <= w_diff;
        r_idx  <= w_k_next;
        r_last <= (w_k_next == 2'(HALF - 1));
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_diff  = r_diff;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// Directed bench for dct_butterfly_stage (SIZE=8, APPROX_BITS=2); inputs and samples move 1ns after posedge.
module tb_dct_butterfly_stage;

  typedef logic signed [7:0] blk_t [8];

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              approx_en;
  logic              out_valid;
  logic              out_ready;
  logic signed [8:0] out_sum;
  logic signed [8:0] out_diff;
  logic [1:0]        out_idx;
  logic              out_last;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dct_butterfly_stage #(
    .SIZE        (8),
    .APPROX_BITS (2),
    .N_POINTS    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic send(input blk_t x, input logic apx0, input logic apxr);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL send_ready beat %0d: in_ready=%b required 1", i, in_ready);
      end
      in_valid  = 1'b1;
      in_data   = x[i];
      approx_en = (i == 0) ? apx0 : apxr;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; approx_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_diff, out_idx, out_last} !== {1'b1, 1'b0, 9'd0, 9'd0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%0d diff=%0d idx=%0d last=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_diff, out_idx, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    blk_t x;
    for (int i = 0; i < 8; i++) x[i] = 8'(i + 1);
    out_ready = 1'b1;
    send(x, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_latency: out_valid=%b required 1 one cycle after x7", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff, out_last} !== {1'b1, 2'(k), 9'sd9, 9'(2*k - 7), 1'(k == 3)}) begin
        n_err++;
        $display("FAIL basic_pair k=%0d: vld=%b idx=%0d sum=%0d diff=%0d last=%b required 1 %0d 9 %0d %0d",
                 k, out_valid, out_idx, out_sum, out_diff, out_last, k, 2*k - 7, (k == 3));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_extremes();
    blk_t x;
    int   es [4];
    int   ed [4];
    x  = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F};
    es = '{254, -1, 0, 0};
    ed = '{0, -255, 0, 0};
    out_ready = 1'b1;
    send(x, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff} !== {1'b1, 2'(k), 9'(es[k]), 9'(ed[k])}) begin
        n_err++;
        $display("FAIL extreme_pair k=%0d: vld=%b idx=%0d sum=%0d diff=%0d required 1 %0d %0d %0d",
                 k, out_valid, out_idx, out_sum, out_diff, k, es[k], ed[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    blk_t x;
    for (int i = 0; i < 8; i++) x[i] = 8'(10 * (i + 1));
    out_ready = 1'b1;
    send(x, 1'b0, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff, out_last} !== {1'b1, 2'd1, 9'sd90, -9'sd50, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold c=%0d: vld=%b idx=%0d sum=%0d diff=%0d last=%b required 1 1 90 -50 0",
                 c, out_valid, out_idx, out_sum, out_diff, out_last);
      end
    end
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff, out_last} !== {1'b1, 2'(k), 9'sd90, 9'(20*k - 70), 1'(k == 3)}) begin
        n_err++;
        $display("FAIL bp_resume k=%0d: vld=%b idx=%0d sum=%0d diff=%0d last=%b required 1 %0d 90 %0d %0d",
                 k, out_valid, out_idx, out_sum, out_diff, out_last, k, 20*k - 70, (k == 3));
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignored_input();
    blk_t a;
    blk_t b;
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'(-(i + 1));
    end
    out_ready = 1'b0;
    send(a, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(100 + c);
      n_cmp++;
      if ({in_ready, out_valid, out_idx} !== {1'b0, 1'b1, 2'd0}) begin
        n_err++;
        $display("FAIL ign_stall c=%0d: in_ready=%b vld=%b idx=%0d required 0 1 0", c, in_ready, out_valid, out_idx);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(50 - k);
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff} !== {1'b1, 2'(k), 9'sd9, 9'(2*k - 7)}) begin
        n_err++;
        $display("FAIL ign_pair k=%0d: vld=%b idx=%0d sum=%0d diff=%0d required 1 %0d 9 %0d",
                 k, out_valid, out_idx, out_sum, out_diff, k, 2*k - 7);
      end
      @(posedge clk); #1;
    end
    send(b, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff} !== {1'b1, 2'(k), -9'sd9, 9'(7 - 2*k)}) begin
        n_err++;
        $display("FAIL ign_next k=%0d: vld=%b idx=%0d sum=%0d diff=%0d required 1 %0d -9 %0d",
                 k, out_valid, out_idx, out_sum, out_diff, k, 7 - 2*k);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_load();
    blk_t x;
    for (int i = 0; i < 8; i++) x[i] = 8'(8 - i);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(60 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_diff, out_idx, out_last} !== {1'b1, 1'b0, 9'd0, 9'd0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_state: rdy=%b vld=%b sum=%0d diff=%0d idx=%0d last=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_diff, out_idx, out_last);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(x, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff, out_last} !== {1'b1, 2'(k), 9'sd9, 9'(7 - 2*k), 1'(k == 3)}) begin
        n_err++;
        $display("FAIL midrst_pair k=%0d: vld=%b idx=%0d sum=%0d diff=%0d last=%b required 1 %0d 9 %0d %0d",
                 k, out_valid, out_idx, out_sum, out_diff, out_last, k, 7 - 2*k, (k == 3));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_approx();
    blk_t x;
    int   se;
    int   de;
    int   ds;
    int   dd;
    out_ready = 1'b1;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 8; i++) x[i] = 8'($urandom_range(0, 255));
      send(x, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
        se = int'(x[k]) + int'(x[7-k]);
        de = int'(x[k]) - int'(x[7-k]);
        ds = int'(out_sum) - se;
        dd = int'(out_diff) - de;
        if (ds < 0) ds = -ds;
        if (dd < 0) dd = -dd;
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== 2'(k) || $isunknown({out_sum, out_diff}) || ds >= 4 || dd >= 4) begin
          n_err++;
          $display("FAIL approx_bound blk=%0d k=%0d: vld=%b idx=%0d sum=%0d diff=%0d required within 3 of %0d %0d",
                   blk, k, out_valid, out_idx, out_sum, out_diff, se, de);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_approx_toggle();
    blk_t x;
    for (int i = 0; i < 8; i++) x[i] = 8'sd3;
    out_ready = 1'b1;
    send(x, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid, out_idx, out_sum, out_diff} !== {1'b1, 2'(k), 9'sd6, 9'sd0}) begin
        n_err++;
        $display("FAIL approx_toggle k=%0d: vld=%b idx=%0d sum=%0d diff=%0d required 1 %0d 6 0",
                 k, out_valid, out_idx, out_sum, out_diff, k);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_ignored_input();
    test_reset_mid_load();
    test_approx();
    test_approx_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
